// File: rtl/stopwatch_core.sv
// rtl/stopwatch_core.sv - BCD MM:SS.hh stopwatch timekeeping core with start/stop, lap-freeze and clear
//
// Ports:
//   clk            system clock
//   rst            synchronous active-high reset
//   tick_in        divider square wave; each rising edge is one hundredth of a second
//   btn_start_stop debounced level; rising edge toggles run/pause
//   btn_lap_reset  debounced level; rising edge enters/leaves lap, or clears while paused
//   min_tens..cs_ones  displayed BCD digits MM:SS.hh
//   running        high while counting (RUN or LAP)
//   lap_active     high while the display is frozen on a lap snapshot
//   overflow       sticky wrap flag, cleared on entry to IDLE

module stopwatch_core #(
   parameter int MINUTES_MAX = 59
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_in,
   input  logic       btn_start_stop,
   input  logic       btn_lap_reset,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic [3:0] cs_tens,
   output logic [3:0] cs_ones,
   output logic       running,
   output logic       lap_active,
   output logic       overflow
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_LAP   = 2'd2,
      S_PAUSE = 2'd3
   } state_t;

   localparam logic [3:0] MAX_TENS = 4'(MINUTES_MAX / 10);
   localparam logic [3:0] MAX_ONES = 4'(MINUTES_MAX % 10);

   state_t state;
   state_t state_nxt;

   logic tick_q, ss_q, lr_q;
   logic tick_rise, ss_ev, lr_ev;
   logic step, wrap, clear, take_snap;

   // live count
   logic [3:0] l_mt, l_mo, l_st, l_so, l_ct, l_co;
   // live count after this edge's optional step
   logic [3:0] n_mt, n_mo, n_st, n_so, n_ct, n_co;
   // lap snapshot
   logic [3:0] s_mt, s_mo, s_st, s_so, s_ct, s_co;

   always_ff @(posedge clk) begin
      if (rst) begin
         tick_q <= 1'b0;
         ss_q   <= 1'b0;
         lr_q   <= 1'b0;
      end else begin
         tick_q <= tick_in;
         ss_q   <= btn_start_stop;
         lr_q   <= btn_lap_reset;
      end
   end

   assign tick_rise = tick_in & ~tick_q;
   assign ss_ev     = btn_start_stop & ~ss_q;
   // start/stop wins when both buttons rise together, so lap/reset is masked
   assign lr_ev     = btn_lap_reset & ~lr_q & ~ss_ev;

   assign step      = tick_rise & ((state == S_RUN) | (state == S_LAP));
   assign clear     = (state == S_PAUSE) & lr_ev;
   // snapshot uses the post-step value so a tick on the lap edge is included
   assign take_snap = (state == S_RUN) & lr_ev;

   // BCD ripple of one hundredth; the full-scale value wraps to zero
   always_comb begin
      n_mt = l_mt;
      n_mo = l_mo;
      n_st = l_st;
      n_so = l_so;
      n_ct = l_ct;
      n_co = l_co;
      wrap = 1'b0;
      if (step) begin
         if ((l_mt == MAX_TENS) && (l_mo == MAX_ONES) && (l_st == 4'd5) &&
             (l_so == 4'd9) && (l_ct == 4'd9) && (l_co == 4'd9)) begin
            n_mt = 4'd0;
            n_mo = 4'd0;
            n_st = 4'd0;
            n_so = 4'd0;
            n_ct = 4'd0;
            n_co = 4'd0;
            wrap = 1'b1;
         end else if (l_co != 4'd9) begin
            n_co = l_co + 4'd1;
         end else begin
            n_co = 4'd0;
            if (l_ct != 4'd9) begin
               n_ct = l_ct + 4'd1;
            end else begin
               n_ct = 4'd0;
               if (l_so != 4'd9) begin
                  n_so = l_so + 4'd1;
               end else begin
                  n_so = 4'd0;
                  if (l_st != 4'd5) begin
                     n_st = l_st + 4'd1;
                  end else begin
                     n_st = 4'd0;
                     if (l_mo != 4'd9) begin
                        n_mo = l_mo + 4'd1;
                     end else begin
                        n_mo = 4'd0;
                        n_mt = l_mt + 4'd1;
                     end
                  end
               end
            end
         end
      end
   end

   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (ss_ev) state_nxt = S_RUN;
         end
         S_RUN: begin
            if (ss_ev)      state_nxt = S_PAUSE;
            else if (lr_ev) state_nxt = S_LAP;
         end
         S_LAP: begin
            if (ss_ev)      state_nxt = S_PAUSE;
            else if (lr_ev) state_nxt = S_RUN;
         end
         S_PAUSE: begin
            if (ss_ev)      state_nxt = S_RUN;
            else if (lr_ev) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // live count, snapshot and overflow
   always_ff @(posedge clk) begin
      if (rst) begin
         l_mt     <= 4'd0;
         l_mo     <= 4'd0;
         l_st     <= 4'd0;
         l_so     <= 4'd0;
         l_ct     <= 4'd0;
         l_co     <= 4'd0;
         s_mt     <= 4'd0;
         s_mo     <= 4'd0;
         s_st     <= 4'd0;
         s_so     <= 4'd0;
         s_ct     <= 4'd0;
         s_co     <= 4'd0;
         overflow <= 1'b0;
      end else begin
         if (clear) begin
            l_mt     <= 4'd0;
            l_mo     <= 4'd0;
            l_st     <= 4'd0;
            l_so     <= 4'd0;
            l_ct     <= 4'd0;
            l_co     <= 4'd0;
            overflow <= 1'b0;
         end else begin
            l_mt <= n_mt;
            l_mo <= n_mo;
            l_st <= n_st;
            l_so <= n_so;
            l_ct <= n_ct;
            l_co <= n_co;
            if (wrap) overflow <= 1'b1;
         end
         if (take_snap) begin
            s_mt <= n_mt;
            s_mo <= n_mo;
            s_st <= n_st;
            s_so <= n_so;
            s_ct <= n_ct;
            s_co <= n_co;
         end
      end
   end

   // outputs decoded from the state register
   always_comb begin
      running    = (state == S_RUN) | (state == S_LAP);
      lap_active = (state == S_LAP);
      if (state == S_LAP) begin
         min_tens = s_mt;
         min_ones = s_mo;
         sec_tens = s_st;
         sec_ones = s_so;
         cs_tens  = s_ct;
         cs_ones  = s_co;
      end else begin
         min_tens = l_mt;
         min_ones = l_mo;
         sec_tens = l_st;
         sec_ones = l_so;
         cs_tens  = l_ct;
         cs_ones  = l_co;
      end
   end

endmodule
